// File: rtl/alias_force_arbiter.sv
// alias_force_arbiter: grants a force on a shared aliased net to one of three
//   requesters, picked round-robin. The winner's value is latched into a hold register.
//   Ports: clk, rst (sync, active-high); req/rel per-requester force/release;
//   fval packed force values; drv normal driver; bus resolved net; gnt one-hot
//   owner; forced high while forced; timeout pulses on auto-release.
// Latency: a grant is visible the cycle after req is sampled. bus follows drv
//   combinationally whenever no force is in effect.
// Backpressure: none. Requests that are not granted stay pending (level) until the next IDLE.
// Optional: define ALIAS_FORCE_TIMEOUT_EN to auto-release a force after HOLD_MAX cycles.
module alias_force_arbiter #(
  parameter int W        = 16,
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     req,
  input  logic [2:0]     rel,
  input  logic [3*W-1:0] fval,
  input  logic [W-1:0]   drv,
  output logic [W-1:0]   bus,
  output logic [2:0]     gnt,
  output logic           forced,
  output logic           timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FORCED  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // The hold counter is 8 bits wide, so HOLD_MAX must fit in 1..255.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("alias_force_arbiter: HOLD_MAX out of range 1..255");
  end

  logic [1:0]   state_q, state_d;
  logic [2:0]   gnt_q, gnt_d;
  logic [W-1:0] hold_q, hold_d;
  logic [1:0]   ptr_q, ptr_d;     // first requester index to search from
  logic         win_vld;
  logic [1:0]   win_idx;
  logic [2:0]   cand;
  logic         expire;

`ifdef ALIAS_FORCE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Compare against HOLD_MAX-1 so that exactly HOLD_MAX FORCED cycles are seen
  // before the edge that moves the FSM into RELEASE.
  assign expire  = (cnt_q == 8'(HOLD_MAX - 1));
  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Round-robin search upward (mod 3) from ptr_q. The loop runs from the farthest
  // candidate down to the nearest, so the nearest pending requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req[cand[1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
`ifdef ALIAS_FORCE_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_FORCED;
          gnt_d   = 3'b001 << win_idx;
          hold_d  = fval[int'(win_idx)*W +: W];
          ptr_d   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`ifdef ALIAS_FORCE_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_FORCED: begin
`ifdef ALIAS_FORCE_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // Only the owner's release strobe counts. req and fval changes are ignored here.
        if (((rel & gnt_q) != 3'b000) || expire) begin
          state_d = S_RELEASE;
          gnt_d   = 3'b000;
`ifdef ALIAS_FORCE_TIMEOUT_EN
          timeout_d = expire;
`endif
        end
      end
      S_RELEASE: begin
        // Unconditional one-cycle gap. Requests are not looked at here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 3'b000;
      hold_q    <= '0;
      ptr_q     <= 2'd0;
`ifdef ALIAS_FORCE_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
`ifdef ALIAS_FORCE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // While reset is held, the net falls back to its normal driver right away,
  // even though the state register only clears at the edge.
  assign bus    = (state_q == S_FORCED && !rst) ? hold_q : drv;
  assign gnt    = gnt_q;
  assign forced = (state_q == S_FORCED);

endmodule

// File: tb/tb_alias_force_arbiter.sv
module tb_alias_force_arbiter;
  localparam int W  = 16;
  localparam int HM = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     req, rel;
  logic [W-1:0]   fv [3];
  logic [3*W-1:0] fval;
  logic [W-1:0]   drv, bus;
  logic [2:0]     gnt;
  logic           forced, timeout;

  always #5 clk = ~clk;
  assign fval = {fv[2], fv[1], fv[0]};

  alias_force_arbiter #(.W(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .fval(fval), .drv(drv),
    .bus(bus), .gnt(gnt), .forced(forced), .timeout(timeout)
  );

  typedef struct packed {
    logic [W-1:0] bus;
    logic [2:0]   gnt;
    logic         forced;
    logic         to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  // Then pop that expectation one half-cycle after the edge and compare.
  task automatic tick(input string nm, input logic r, input logic [2:0] rq,
                      input logic [2:0] rl, input logic [W-1:0] d,
                      input logic [W-1:0] eb, input logic [2:0] eg,
                      input logic ef, input logic et);
    exp_t e;
    rst = r; req = rq; rel = rl; drv = d;
    sb.push_back(exp_t'{eb, eg, ef, et});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({nm, ".bus"},     32'(bus),     32'(e.bus));
    check({nm, ".gnt"},     32'(gnt),     32'(e.gnt));
    check({nm, ".forced"},  32'(forced),  32'(e.forced));
    check({nm, ".timeout"}, 32'(timeout), 32'(e.to));
  endtask

  initial begin
    logic [2:0] oh;
    rst = 1'b1; req = '0; rel = '0; drv = '0;
    fv[0] = '0; fv[1] = '0; fv[2] = '0;
    @(negedge clk);

    // Reset state: the net shows drv and no force is in effect.
    tick("rst", 1'b1, 3'b000, 3'b000, 16'h0055, 16'h0055, 3'b000, 1'b0, 1'b0);

    // Single requester: force, hold, release, then back to drv.
    fv[0] = 16'h1234;
    tick("f0_c1",  1'b0, 3'b001, 3'b000, 16'h0000, 16'h1234, 3'b001, 1'b1, 1'b0);
    tick("f0_c2",  1'b0, 3'b000, 3'b000, 16'h0000, 16'h1234, 3'b001, 1'b1, 1'b0);
    tick("f0_rel", 1'b0, 3'b000, 3'b001, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);
    tick("f0_idl", 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);

    // Reset restores requester 0 as highest priority. All three then request together.
    tick("rst2", 1'b1, 3'b000, 3'b000, 16'h0f0f, 16'h0f0f, 3'b000, 1'b0, 1'b0);
    fv[0] = 16'h1234; fv[1] = 16'h5678; fv[2] = 16'habcd;
    for (int i = 0; i < 3; i++) begin
      oh = 3'b001 << i;
      tick($sformatf("rr%0d_c1", i),  1'b0, 3'b111, 3'b000, 16'h0f0f, fv[i],    oh,     1'b1, 1'b0);
      tick($sformatf("rr%0d_c2", i),  1'b0, 3'b111, 3'b000, 16'h0f0f, fv[i],    oh,     1'b1, 1'b0);
      tick($sformatf("rr%0d_rel", i), 1'b0, 3'b111, oh,     16'h0f0f, 16'h0f0f, 3'b000, 1'b0, 1'b0);
      tick($sformatf("rr%0d_idl", i), 1'b0, 3'b111, 3'b000, 16'h0f0f, 16'h0f0f, 3'b000, 1'b0, 1'b0);
    end
    tick("rr_done", 1'b0, 3'b000, 3'b000, 16'h0f0f, 16'h0f0f, 3'b000, 1'b0, 1'b0);

    // Owner 0 again (pointer wrapped). Non-owner rel and a new fval are both ignored.
    fv[0] = 16'h1234;
    tick("ign_c1", 1'b0, 3'b001, 3'b000, 16'h0000, 16'h1234, 3'b001, 1'b1, 1'b0);
    fv[0] = 16'hffff;
    tick("ign_c2", 1'b0, 3'b001, 3'b010, 16'h0000, 16'h1234, 3'b001, 1'b1, 1'b0);
    tick("ign_c3", 1'b0, 3'b000, 3'b000, 16'h0000, 16'h1234, 3'b001, 1'b1, 1'b0);
    tick("ign_rel", 1'b0, 3'b000, 3'b001, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);
    tick("idle_rel", 1'b0, 3'b000, 3'b111, 16'h0033, 16'h0033, 3'b000, 1'b0, 1'b0);

    // Reset during the second FORCED cycle drops the force with no RELEASE or timeout.
    fv[0] = 16'h1234;
    tick("mr_c1", 1'b0, 3'b001, 3'b000, 16'h00aa, 16'h1234, 3'b001, 1'b1, 1'b0);
    tick("mr_c2", 1'b0, 3'b000, 3'b000, 16'h00aa, 16'h1234, 3'b001, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("mr_bus_during_rst", 32'(bus), 32'h00aa);
    tick("mr_rst", 1'b1, 3'b000, 3'b000, 16'h00aa, 16'h00aa, 3'b000, 1'b0, 1'b0);
    tick("mr_aft", 1'b0, 3'b000, 3'b000, 16'h00aa, 16'h00aa, 3'b000, 1'b0, 1'b0);

    // Requester 1 holds with no release.
    fv[1] = 16'h5678;
`ifdef ALIAS_FORCE_TIMEOUT_EN
    // The second run also releases on the expiry edge. The release wins and timeout still pulses.
    for (int run = 0; run < 2; run++) begin
      tick($sformatf("to%0d_c1", run), 1'b0, 3'b010, 3'b000, 16'h00aa, 16'h5678, 3'b010, 1'b1, 1'b0);
      for (int c = 2; c <= HM; c++)
        tick($sformatf("to%0d_c%0d", run, c), 1'b0, 3'b010, 3'b000, 16'h00aa, 16'h5678, 3'b010, 1'b1, 1'b0);
      tick($sformatf("to%0d_exp", run), 1'b0, 3'b010, (run == 1) ? 3'b010 : 3'b000,
           16'h00aa, 16'h00aa, 3'b000, 1'b0, 1'b1);
      tick($sformatf("to%0d_idl", run), 1'b0, 3'b000, 3'b000, 16'h00aa, 16'h00aa, 3'b000, 1'b0, 1'b0);
    end
`else
    tick("hold_c1", 1'b0, 3'b010, 3'b000, 16'h00aa, 16'h5678, 3'b010, 1'b1, 1'b0);
    for (int c = 2; c <= 100; c++)
      tick($sformatf("hold_c%0d", c), 1'b0, 3'b010, 3'b000, 16'h00aa, 16'h5678, 3'b010, 1'b1, 1'b0);
    tick("hold_rel", 1'b0, 3'b000, 3'b010, 16'h00aa, 16'h00aa, 3'b000, 1'b0, 1'b0);
    tick("hold_idl", 1'b0, 3'b000, 3'b000, 16'h00aa, 16'h00aa, 3'b000, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
